regfile_pe: RTL and testbench
=============================

# regfile_pe

Parametrised posedge register bank with asynchronous active-low reset: DEPTH registers of WIDTH bits, one write port with an operation select (load / increment / decrement / clear), two combinational read ports and an optional write-bypass path. It succeeds the single 8-bit enable-register variants. It is the general-purpose register storage for the CDEC datapath on DE0.

## Interface
Parameters:
- WIDTH, 8, data width of each register (≥2)
- DEPTH, 4, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- RESET_VAL, 0, value every register takes on reset (WIDTH bits)
- ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes
- BYPASS, 1, when 1 a read of the register being written returns the value it will hold after the edge

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_N  in  1  asynchronous, active-low reset
- wr_en  in  1  commit op to register wr_addr at next rising edge
- op  in  2  00 LOAD, 01 INC, 10 DEC, 11 CLR
- wr_addr  in  AW  target register
- in  in  WIDTH  data for LOAD (ignored by other ops)
- rd_addr_a  in  AW  read port A address
- out_a  out  WIDTH  read port A data
- rd_addr_b  in  AW  read port B address
- out_b  out  WIDTH  read port B data
- ovf  out  1  registered wrap flag of the last committed write

## Operation
- Next value nv for target r: LOAD→in; INC→r+1 mod 2^WIDTH; DEC→r−1 mod 2^WIDTH; CLR→0.
- wr_en=1 at rising edge: reg[wr_addr] ← nv; ovf ← 1 if INC from all-ones or DEC from 0, else 0.
- wr_en=0: all registers and ovf hold.
- ZERO_REG=1 and wr_addr=0: write discarded, ovf holds, reg 0 stays 0 (reads 0 regardless of RESET_VAL).
- Reads combinational: out_x = reg[rd_addr_x]. Both ports may address the same register.
- BYPASS=1, wr_en=1, rd_addr_x=wr_addr (and write not discarded): out_x = nv. BYPASS=0: out_x shows old value until the edge.
- Reset (reset_N=0): all registers ← RESET_VAL (reg 0 → 0 if ZERO_REG), ovf ← 0, immediately, independent of clock; writes ignored while low.

## Timing
- Write latency: one edge; new value visible on out_x after the rising edge (same cycle via bypass when enabled).
- Read latency: zero (combinational from address).
- Reset assertion mid-cycle overrides a coinciding write; rising edge with reset_N=0 changes nothing.
- First write accepted on the first rising edge with reset_N=1 at that edge.
- Reset values: every register RESET_VAL, out_a/out_b = RESET_VAL (0 for reg 0 under ZERO_REG), ovf = 0.
- Back-to-back INC on one register each cycle: increments accumulate, one per edge, no stalls.

## Structure
- Package regfile_pkg: op encoding constants OP_LOAD, OP_INC, OP_DEC, OP_CLR and the 2-bit op type.
- Sub-module reg_cell: one WIDTH-bit register with clock, reset_N, wr_en, in, out, RESET_VAL parameter; instantiated DEPTH times via generate. Next-value/ovf logic and read muxes live in the top.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'h5A; assert reset_N=0 between edges → out_a=out_b=8'h5A, ovf=0 immediately, not at next edge.
- LOAD/read: write 8'hAA to r1, 8'h99 to r2, read A=r1, B=r2 → out_a=8'hAA, out_b=8'h99 after respective edges; wr_en=0 with in=8'h55 → unchanged.
- Wrap: LOAD r3=8'hFF, INC → r3=8'h00, ovf=1; next DEC r3 → 8'hFF, ovf=1; LOAD 8'h11 → ovf=0.
- Bypass: BYPASS=1, r1=8'h10, INC r1 with rd_addr_a=1 → out_a=8'h11 before edge; BYPASS=0 → out_a=8'h10 until edge.
- ZERO_REG=1: LOAD r0=8'hFF → out_a(r0)=0, ovf unchanged; CLR r2 → r2=0.
- Reset mid-operation: wr_en=1 LOAD 8'h33 with reset_N=0 across edge → register stays RESET_VAL; after release, same write lands next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_pe register bank: write-port
// operation encoding and a small helper used by the next-value logic.
package regfile_pkg;

    // Write-port operation select.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // Raw 2-bit op type as it appears on the port.
    typedef logic [1:0] op_t;

    // True when the op wraps the register around: INC from all-ones or
    // DEC from zero. Takes the reduction results so it stays width-agnostic.
    function automatic logic op_wraps(input op_t op_i,
                                      input logic all_ones_i,
                                      input logic all_zero_i);
        logic wrap_v;
        case (op_i)
            OP_INC:  wrap_v = all_ones_i;
            OP_DEC:  wrap_v = all_zero_i;
            OP_LOAD: wrap_v = 1'b0;
            OP_CLR:  wrap_v = 1'b0;
            default: wrap_v = 1'b0;
        endcase
        return wrap_v;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_pe_reg_cell.sv
// One WIDTH-bit storage register of the regfile_pe bank. Loads `in`
// on a rising edge when wr_en is high, otherwise holds. Asynchronous
// active-low reset to RESET_VAL.
module reg_cell #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state: take the new value when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            data_d = in;
        end else begin
            data_d = data_q;
        end
    end

    // Storage flop with asynchronous reset.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule : reg_cell

// File: rtl/regfile_pe.sv
// regfile_pe: DEPTH x WIDTH register bank with one write port carrying
// an operation (load / increment / decrement / clear), two combinational
// read ports, an optional write-through bypass and an optional
// hard-wired zero register. ovf records whether the last committed
// write wrapped around.
module regfile_pe
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               ZERO_REG  = 1'b0,
    parameter bit               BYPASS    = 1'b1,
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_N,
    input  logic             wr_en,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] out_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] out_b,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [AW-1:0]    ADDR0    = {AW{1'b0}};

    logic [WIDTH-1:0] reg_val_s [DEPTH];
    logic [DEPTH-1:0] cell_we_s;
    logic [WIDTH-1:0] cur_val_s;
    logic [WIDTH-1:0] nv_s;
    logic             wrap_s;
    logic             write_ok_s;
    logic             ovf_d;
    logic             ovf_q;

    // Current contents of the write target, the operand for INC/DEC.
    always_comb begin
        cur_val_s = reg_val_s[wr_addr];
    end

    // Next value of the write target for the selected op.
    always_comb begin
        nv_s = cur_val_s;
        case (op_e'(op))
            OP_LOAD: nv_s = in;
            OP_INC:  nv_s = cur_val_s + ONE_VAL;
            OP_DEC:  nv_s = cur_val_s - ONE_VAL;
            OP_CLR:  nv_s = ZERO_VAL;
            default: nv_s = cur_val_s;
        endcase
    end

    // Wrap detection for the ovf flag.
    always_comb begin
        wrap_s = op_wraps(op, &cur_val_s, ~|cur_val_s);
    end

    // A write commits only out of reset and not to a hard-wired zero reg.
    always_comb begin
        write_ok_s = 1'b0;
        if (reset_N && wr_en) begin
            if (ZERO_REG && (wr_addr == ADDR0)) begin
                write_ok_s = 1'b0;
            end else begin
                write_ok_s = 1'b1;
            end
        end else begin
            write_ok_s = 1'b0;
        end
    end

    // One-hot write enable to the addressed cell.
    always_comb begin
        cell_we_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (write_ok_s && (wr_addr == AW'(i))) begin
                cell_we_s[i] = 1'b1;
            end else begin
                cell_we_s[i] = 1'b0;
            end
        end
    end

    // ovf follows the wrap of each committed write, holds otherwise.
    always_comb begin
        ovf_d = ovf_q;
        if (write_ok_s) begin
            ovf_d = wrap_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // ovf flag register.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    // Storage cells. Under ZERO_REG, cell 0 resets to zero and is never
    // enabled, so it stays zero whatever RESET_VAL is.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        localparam logic [WIDTH-1:0] CELL_RST =
            (ZERO_REG && (g == 0)) ? ZERO_VAL : RESET_VAL;

        reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (CELL_RST)
        ) u_cell (
            .clock   (clock),
            .reset_N (reset_N),
            .wr_en   (cell_we_s[g]),
            .in      (nv_s),
            .out     (reg_val_s[g])
        );
    end

    // Read port A: zero register, then bypass of a pending write, then storage.
    always_comb begin
        out_a = reg_val_s[rd_addr_a];
        if (ZERO_REG && (rd_addr_a == ADDR0)) begin
            out_a = ZERO_VAL;
        end else if (BYPASS && write_ok_s && (rd_addr_a == wr_addr)) begin
            out_a = nv_s;
        end else begin
            out_a = reg_val_s[rd_addr_a];
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        out_b = reg_val_s[rd_addr_b];
        if (ZERO_REG && (rd_addr_b == ADDR0)) begin
            out_b = ZERO_VAL;
        end else if (BYPASS && write_ok_s && (rd_addr_b == wr_addr)) begin
            out_b = nv_s;
        end else begin
            out_b = reg_val_s[rd_addr_b];
        end
    end

endmodule : regfile_pe

// File: tb/tb_regfile_pe.sv
// Bench for regfile_pe: three instances share one stimulus stream
//   u_dut0: BYPASS=1, ZERO_REG=0
//   u_dut1: BYPASS=0, ZERO_REG=0
//   u_dut2: BYPASS=1, ZERO_REG=1
// all with WIDTH=8, DEPTH=4, RESET_VAL=8'h5A. An array model tracks the
// register contents with plain integer arithmetic; a compare process
// checks every falling edge, and directed steps pin literal values.
module tb_regfile_pe;

    localparam int NDUT = 3;

    logic             clock = 1'b0;
    logic             reset_N;
    logic             wr_en;
    logic [1:0]       op;
    logic [1:0]       wr_addr;
    logic [7:0]       din;
    logic [1:0]       rd_addr_a;
    logic [1:0]       rd_addr_b;
    logic [NDUT-1:0][7:0] oa;
    logic [NDUT-1:0][7:0] ob;
    logic [NDUT-1:0]  ovf_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int unsigned mem [NDUT][4];
    bit          movf [NDUT];

    always #5 clock = ~clock;

    regfile_pe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
        .clock(clock), .reset_N(reset_N), .wr_en(wr_en), .op(op), .wr_addr(wr_addr), .in(din),
        .rd_addr_a(rd_addr_a), .out_a(oa[0]), .rd_addr_b(rd_addr_b), .out_b(ob[0]), .ovf(ovf_o[0]));
    regfile_pe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .clock(clock), .reset_N(reset_N), .wr_en(wr_en), .op(op), .wr_addr(wr_addr), .in(din),
        .rd_addr_a(rd_addr_a), .out_a(oa[1]), .rd_addr_b(rd_addr_b), .out_b(ob[1]), .ovf(ovf_o[1]));
    regfile_pe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut2 (
        .clock(clock), .reset_N(reset_N), .wr_en(wr_en), .op(op), .wr_addr(wr_addr), .in(din),
        .rd_addr_a(rd_addr_a), .out_a(oa[2]), .rd_addr_b(rd_addr_b), .out_b(ob[2]), .ovf(ovf_o[2]));

    function automatic bit zr_of(input int k);
        return (k == 2);
    endfunction

    function automatic bit bp_of(input int k);
        return (k != 1);
    endfunction

    // Value after applying the op, modulo 256.
    function automatic int unsigned nv_of(input int unsigned old, input logic [1:0] o, input logic [7:0] d);
        case (o)
            2'd0:    return int'(d);
            2'd1:    return (old + 1) % 256;
            2'd2:    return (old + 255) % 256;
            default: return 0;
        endcase
    endfunction

    function automatic bit wrap_of(input int unsigned old, input logic [1:0] o);
        return ((o == 2'd1) && (old == 255)) || ((o == 2'd2) && (old == 0));
    endfunction

    function automatic bit commits(input int k);
        return (reset_N === 1'b1) && (wr_en === 1'b1) && !(zr_of(k) && (wr_addr == 2'd0));
    endfunction

    // Expected read data for instance k at address a, given current inputs.
    function automatic logic [31:0] exp_rd(input int k, input logic [1:0] a);
        if (zr_of(k) && (a == 2'd0)) return 32'd0;
        if (bp_of(k) && commits(k) && (a == wr_addr)) return nv_of(mem[k][a], op, din);
        return mem[k][a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state update.
    always @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            for (int k = 0; k < NDUT; k++) begin
                for (int i = 0; i < 4; i++) begin
                    mem[k][i] <= (zr_of(k) && (i == 0)) ? 32'd0 : 32'h5A;
                end
                movf[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (commits(k)) begin
                    mem[k][wr_addr] <= nv_of(mem[k][wr_addr], op, din);
                    movf[k] <= wrap_of(mem[k][wr_addr], op);
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("out_a[%0d]", k), oa[k], exp_rd(k, rd_addr_a));
                chk($sformatf("out_b[%0d]", k), ob[k], exp_rd(k, rd_addr_b));
                chk($sformatf("ovf[%0d]", k), ovf_o[k], movf[k]);
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] o, input logic [1:0] wa,
                         input logic [7:0] d, input logic [1:0] ra, input logic [1:0] rb);
        wr_en = we; op = o; wr_addr = wa; din = d; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_N = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
        step();
        // Reset values.
        chk("rst_a_r0", oa[0], 8'h5A);
        chk("rst_b_r1", ob[0], 8'h5A);
        chk("rst_zero_r0", oa[2], 8'h00);
        chk("rst_ovf", ovf_o[0], 1'b0);
        #2 reset_N = 1'b1;
        cmp_en = 1'b1;
        step();

        // LOAD and read.
        drive(1'b1, 2'd0, 2'd1, 8'hAA, 2'd1, 2'd2);
        step();
        drive(1'b1, 2'd0, 2'd2, 8'h99, 2'd1, 2'd2);
        #1 chk("load_r1", oa[1], 8'hAA);
        step();
        drive(1'b0, 2'd0, 2'd2, 8'h55, 2'd1, 2'd2);
        #1 chk("load_r2", ob[1], 8'h99);
        step();
        chk("hold_r1", oa[0], 8'hAA);
        chk("hold_r2", ob[0], 8'h99);
        chk("model_r2", mem[0][2], 32'h99);

        // Wrap in both directions, then LOAD clears ovf.
        drive(1'b1, 2'd0, 2'd3, 8'hFF, 2'd3, 2'd3);
        step();
        drive(1'b1, 2'd1, 2'd3, 8'h00, 2'd3, 2'd3);
        step();
        chk("inc_wrap_val", oa[1], 8'h00);
        chk("inc_wrap_ovf", ovf_o[1], 1'b1);
        drive(1'b1, 2'd2, 2'd3, 8'h00, 2'd3, 2'd3);
        step();
        chk("dec_wrap_val", oa[1], 8'hFF);
        chk("dec_wrap_ovf", ovf_o[1], 1'b1);
        drive(1'b1, 2'd0, 2'd3, 8'h11, 2'd3, 2'd3);
        step();
        chk("load_ovf_clr", ovf_o[1], 1'b0);
        chk("load_r3", oa[1], 8'h11);

        // Bypass versus no bypass.
        drive(1'b1, 2'd0, 2'd1, 8'h10, 2'd1, 2'd1);
        step();
        drive(1'b1, 2'd1, 2'd1, 8'h00, 2'd1, 2'd1);
        #1 chk("bypass_on", oa[0], 8'h11);
        chk("bypass_off", oa[1], 8'h10);
        step();
        drive(1'b0, 2'd1, 2'd1, 8'h00, 2'd1, 2'd1);
        #1 chk("bypass_off_after", oa[1], 8'h11);

        // Zero register: write discarded, ovf holds.
        drive(1'b1, 2'd0, 2'd3, 8'hFF, 2'd3, 2'd3);
        step();
        drive(1'b1, 2'd1, 2'd3, 8'h00, 2'd3, 2'd3);
        step();
        drive(1'b1, 2'd0, 2'd0, 8'hFF, 2'd0, 2'd2);
        step();
        drive(1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd2);
        #1 chk("zr_r0", oa[2], 8'h00);
        chk("zr_ovf_hold", ovf_o[2], 1'b1);
        chk("nzr_r0", oa[0], 8'hFF);
        chk("nzr_ovf", ovf_o[0], 1'b0);
        drive(1'b1, 2'd3, 2'd2, 8'h77, 2'd0, 2'd2);
        step();
        drive(1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd2);
        #1 chk("zr_clr_r2", ob[2], 8'h00);
        chk("clr_r2", ob[1], 8'h00);

        // Reset mid-cycle overrides a coinciding write.
        drive(1'b1, 2'd0, 2'd1, 8'h33, 2'd1, 2'd1);
        #1 reset_N = 1'b0;
        #1 chk("rst_now_nb", oa[1], 8'h5A);
        chk("rst_now_bp", oa[0], 8'h5A);
        chk("rst_now_ovf", ovf_o[0], 1'b0);
        step();
        chk("rst_edge_r1", oa[1], 8'h5A);
        reset_N = 1'b1;
        #1 chk("rel_bypass", oa[0], 8'h33);
        chk("rel_nobypass", oa[1], 8'h5A);
        step();
        chk("rel_write", oa[1], 8'h33);
        chk("model_r1", mem[1][1], 32'h33);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 49) == 0) begin
                #2 reset_N = 1'b0;
                #4 reset_N = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_pe
